// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for an RV64 datapath that shares one ALU and one
// memory port. It supports LD, SD, R-type and BEQ, counts retired
// instructions, and has a watchdog that stops the core if memory stalls.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_sel,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             error,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        EXECUTE, ALU_WB, BRANCH, TRAP, ERROR
    } state_t;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // The watchdog fires on the cycle that would bring the wait count up to
    // MEM_TIMEOUT. A mem_ready in that same cycle still counts as success.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [RET_W-1:0]   retired_q, retired_d;
    logic               is_ld, is_sd, is_r, is_beq;
    logic               retire;

    assign is_ld  = (opcode == OP_LD) && (funct3 == 3'b011);
    assign is_sd  = (opcode == OP_SD) && (funct3 == 3'b011);
    assign is_r   = (opcode == OP_R);
    assign is_beq = (opcode == OP_BR) && (funct3 == 3'b000);

    // State, watchdog and retire counter registers. Reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            tmo_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic, Moore control outputs, watchdog and retire update.
    always_comb begin
        state_d    = state_q;
        tmo_d      = '0;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'b00;
        imm_sel    = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        error      = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                imm_sel   = 2'd2;
                if (is_ld || is_sd) state_d = MEM_ADDR;
                else if (is_r)      state_d = EXECUTE;
                else if (is_beq)    state_d = BRANCH;
                else                state_d = TRAP;
            end
            MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                imm_sel   = (opcode == OP_SD) ? 2'd1 : 2'd0;
                state_d   = (opcode == OP_SD) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 2'd1;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
                state_d = FETCH;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Request states count consecutive stalled cycles; leaving or
        // completing the request clears the counter.
        if (mem_req && !mem_ready) begin
            tmo_d = tmo_q + TMO_W'(1);
            if ((MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                state_d = ERROR;
            end
        end

        retired_d = retired_q + RET_W'(retire);
        retired   = (state_q == ERROR) ? '0 : retired_q;

        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 2'b00;
            imm_sel    = 2'd0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
            error      = 1'b0;
            retired    = '0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the 64-bit RV64 datapath over multiple cycles per instruction, sharing one ALU and one memory port across fetch, address and execute phases.
- Decodes the opcode and funct3 from the instruction register and drives:
  - immediate-format select to the immediate generator;
  - ALU operand and operation selects;
  - PC and IR write enables;
  - the memory request handshake and register-file write enable.
- Supports LD, SD, R-type and BEQ. Also keeps a retired-instruction counter and a memory-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles a memory request may wait for mem_ready before ERROR. 0 disables the watchdog.
- TMO_W, 8: width of the watchdog counter. Must satisfy 2^TMO_W > MEM_TIMEOUT.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the IR.
- funct3  in  3  instr[14:12] from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (SD), 0 = read.
- ir_write  out  1  latch fetched instruction into IR.
- pc_write  out  1  update PC.
- pc_src  out  1  PC source: 0 = ALU result (PC+4), 1 = ALU-out register (branch target).
- alu_src_a  out  2  operand A select: 0 = PC, 1 = rs1, 2 = old PC.
- alu_src_b  out  2  operand B select: 0 = rs2, 1 = constant 4, 2 = immediate.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode from funct fields.
- imm_sel  out  2  immediate format: 0 = I, 1 = S, 2 = B.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU-out.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- error  out  1  sticky memory-timeout flag.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset:
  - rst=1 forces state FETCH immediately, regardless of the clock.
  - Clears the retired counter, the watchdog counter and error.
  - While rst=1, every output is 0 (mem_req, ir_write, pc_write, reg_write, illegal, error, retired) and every select is 0.
  - Reset mid-instruction abandons that instruction with no retire.
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, TRAP, ERROR.
- FETCH:
  - mem_req=1, mem_we=0.
  - alu_src_a=0, alu_src_b=1, alu_op=00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1; pc_src=0. The FSM then goes to DECODE, otherwise it stays in FETCH.
- DECODE:
  - alu_src_a=2, alu_src_b=2, imm_sel=2, alu_op=00, so the branch target lands in ALU-out.
  - Next state by opcode:
    - LD: 0000011 with funct3=011 goes to MEM_ADDR.
    - SD: 0100011 with funct3=011 goes to MEM_ADDR.
    - R-type: 0110011 goes to EXECUTE.
    - BEQ: 1100011 with funct3=000 goes to BRANCH.
    - Anything else goes to TRAP.
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=2, alu_op=00.
  - imm_sel=0 for LD, 1 for SD.
  - Next state is MEM_READ for LD, MEM_WRITE for SD.
- MEM_READ: mem_req=1, mem_we=0. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Retires, then goes to FETCH.
- MEM_WRITE: mem_req=1, mem_we=1. Holds until mem_ready=1; retires in that cycle and goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Retires, then goes to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_write=zero.
  - Retires, then goes to FETCH.
- TRAP: illegal=1 for exactly one cycle, no retire, then FETCH. The PC was already advanced, so the instruction is skipped.
- Handshake:
  - mem_req stays high and mem_we stays stable until the mem_ready cycle.
  - mem_ready is ignored in any state without mem_req.
- Watchdog:
  - The counter clears on entry to each request state and increments on every cycle of that state with mem_ready=0.
  - With MEM_TIMEOUT>0, when the count reaches MEM_TIMEOUT while still waiting, the FSM goes to ERROR.
  - ERROR: error=1, all other outputs 0. Only rst exits ERROR.
  - mem_ready=1 arriving in the same cycle as the count reaching the limit counts as success; no ERROR.
- Retired counter: +1 on each retiring cycle, wraps modulo 2^RET_W.
- Latency with mem_ready tied high: R-type 4 cycles, LD 5, SD 4, BEQ 3, illegal 3.

Test Plan:
- Reset, mem_ready=1, opcode=0110011 -> states FETCH,DECODE,EXECUTE,ALU_WB. reg_write=1 only in cycle 4. retired increments 0->1 in cycle 4.
- LD (0000011/011), mem_ready low 3 cycles in MEM_READ -> mem_req held 4 cycles with mem_we=0. MEM_WB has reg_write=1, mem_to_reg=1. Total 8 cycles, retired=1.
- BEQ (1100011/000), run twice with zero=1 then zero=0 -> BRANCH has pc_write=1, pc_src=1 when zero=1 and pc_write=0 when zero=0. retired=2.
- opcode=1111111 -> TRAP gives illegal=1 for one cycle, retired unchanged, back to FETCH. SD with funct3=010 also traps.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERROR after 4 waiting cycles, error=1, mem_req=0. Stays there until rst. A variant with mem_ready=1 on the 4th waiting cycle completes normally.
- Assert rst asynchronously mid-MEM_WRITE (between clock edges) -> outputs 0 immediately, FETCH after release, retired=0.
